// File: rtl/uart_tx_queue_pkg.sv
// Shared UART definitions: serializer byte width, queue defaults and the
// launch FSM state encoding used by uart_tx_queue.
package uart_tx_queue_pkg;

  localparam int UART_DATA_BITS        = 8;
  localparam int DEFAULT_DEPTH         = 16;
  localparam int DEFAULT_START_TIMEOUT = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } tx_state_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// Circular-buffer byte FIFO with registered full/empty/count flags and a
// one-cycle overflow pulse for writes presented while full.
module sync_fifo
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_N,
  input  logic                          i_Wr_En,
  input  logic [UART_DATA_BITS-1:0]     i_Wr_Data,
  input  logic                          i_Pop,
  output logic [UART_DATA_BITS-1:0]     o_Rd_Data,
  output logic                          o_Full,
  output logic                          o_Empty,
  output logic [$clog2(DEPTH):0]        o_Count,
  output logic                          o_Overflow
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [CW-1:0]             count_nxt;
  logic                      wr_ok;
  logic                      rd_ok;

  // Acceptance uses the registered flags so the producer sees a stable decision.
  assign wr_ok     = i_Wr_En & ~o_Full;
  assign rd_ok     = i_Pop & ~o_Empty;
  assign o_Rd_Data = mem[rd_ptr];

  always_comb begin
    count_nxt = o_Count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = o_Count + CW'(1);
      2'b01:   count_nxt = o_Count - CW'(1);
      default: count_nxt = o_Count;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_Count    <= '0;
      o_Full     <= 1'b0;
      o_Empty    <= 1'b1;
      o_Overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      o_Count    <= count_nxt;
      o_Full     <= (count_nxt == CW'(DEPTH));
      o_Empty    <= (count_nxt == '0);
      o_Overflow <= i_Wr_En & o_Full;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (wr_ok) mem[wr_ptr] <= i_Wr_Data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of a UART serializer: buffers producer writes and
// launches them one at a time, waiting for the serializer to go busy and idle.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
  input  logic                      i_Clock,
  input  logic                      i_Rst_N,
  input  logic                      i_Wr_En,
  input  logic [UART_DATA_BITS-1:0] i_Wr_Data,
  output logic                      o_Full,
  output logic                      o_Empty,
  output logic [$clog2(DEPTH):0]    o_Count,
  output logic                      o_Overflow,
  output logic                      o_Tx_DV,
  output logic [UART_DATA_BITS-1:0] o_Tx_Byte,
  input  logic                      i_Tx_Active
);

  localparam int TW = $clog2(START_TIMEOUT) + 1;

  tx_state_e                 state;
  tx_state_e                 state_nxt;
  logic [TW-1:0]             timer;
  logic                      launch;
  logic [UART_DATA_BITS-1:0] head;

  sync_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Rst_N   (i_Rst_N),
    .i_Wr_En   (i_Wr_En),
    .i_Wr_Data (i_Wr_Data),
    .i_Pop     (launch),
    .o_Rd_Data (head),
    .o_Full    (o_Full),
    .o_Empty   (o_Empty),
    .o_Count   (o_Count),
    .o_Overflow(o_Overflow)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_N) begin
    if (!i_Rst_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // A serializer that never asserts busy is treated as having sent the byte.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (!o_Empty && !i_Tx_Active) state_nxt = WAIT_START;
      WAIT_START: if (i_Tx_Active)                          state_nxt = WAIT_DONE;
                  else if (timer == TW'(START_TIMEOUT - 1)) state_nxt = IDLE;
      WAIT_DONE:  if (!i_Tx_Active) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    launch = (state == IDLE) && !o_Empty && !i_Tx_Active;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      timer     <= '0;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= '0;
    end else begin
      timer   <= (state == WAIT_START) ? timer + TW'(1) : '0;
      o_Tx_DV <= launch;
      if (launch) o_Tx_Byte <= head;
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue with a behavioural serializer that
// answers launches after random delays, or not at all to exercise the timeout.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int TO    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_active = 1'b0;
  logic       full, empty, ovf, dv;
  logic [7:0] tx_byte;
  logic [4:0] count;

  always #16 clk = ~clk;

  uart_tx_queue #(.DEPTH(DEPTH), .START_TIMEOUT(TO)) dut (
    .i_Clock    (clk),
    .i_Rst_N    (rst_n),
    .i_Wr_En    (wr_en),
    .i_Wr_Data  (wr_data),
    .o_Full     (full),
    .o_Empty    (empty),
    .o_Count    (count),
    .o_Overflow (ovf),
    .o_Tx_DV    (dv),
    .o_Tx_Byte  (tx_byte),
    .i_Tx_Active(tx_active)
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;
  int         cyc = 0;
  int         launches = 0;
  bit         force_hi = 0, no_resp = 0, rand_to = 0;
  int         len_lo = 1, len_hi = 6;
  bit         ser_pend = 0, ser_busy = 0;
  int         ser_dly = 0, ser_len = 0;
  int         gap_exp = 0, gap_ref = 0;
  bit         prev_dv = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: a queue of bytes capped at DEPTH; a write is kept only if there is room.
  initial forever begin
    @(posedge clk);
    if (rst_n && wr_en) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(wr_data);
        exp_ovf = 1'b0;
      end else begin
        exp_ovf = 1'b1;
      end
    end else begin
      exp_ovf = 1'b0;
    end
  end

  // Monitor plus serializer model, evaluated on the falling edge.
  initial forever begin
    logic [7:0] exp_b;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (dv) begin
        launches++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_launch: got byte 0x%02h expected no launch", tx_byte);
        end else begin
          exp_b = exp_q.pop_front();
          chk("tx_byte_order", tx_byte, exp_b);
        end
        chk("launch_while_busy", tx_active, 0);
        chk("dv_one_cycle", prev_dv, 0);
        if (gap_exp != 0) chk("launch_gap", cyc - gap_ref, gap_exp);
        gap_exp = 0;
        if (!force_hi) begin
          if (no_resp || (rand_to && $urandom_range(0, 7) == 0)) begin
            if (exp_q.size() > 0) begin
              gap_exp = TO + 1;
              gap_ref = cyc;
            end
          end else begin
            ser_pend = 1;
            ser_dly  = $urandom_range(0, 2);
            ser_len  = $urandom_range(len_lo, len_hi);
          end
        end
      end
      chk("count", count, exp_q.size());
      chk("empty", empty, int'(exp_q.size() == 0));
      chk("full", full, int'(exp_q.size() == DEPTH));
      chk("overflow", ovf, exp_ovf);
      prev_dv = dv;
    end else begin
      prev_dv = 0;
    end
    if (ser_pend) begin
      if (ser_dly == 0) begin
        ser_pend = 0;
        ser_busy = 1;
      end else begin
        ser_dly--;
      end
    end else if (ser_busy) begin
      if (ser_len <= 1) begin
        ser_busy = 0;
        if (rst_n && !force_hi && exp_q.size() > 0) begin
          gap_exp = 2;
          gap_ref = cyc;
        end
      end else begin
        ser_len--;
      end
    end
    tx_active = force_hi | ser_busy;
  end

  task automatic drain();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !ser_busy && !ser_pend) break;
      @(negedge clk);
    end
    chk("drain_timeout", int'(i >= 3000), 0);
    repeat (TO + 4) @(negedge clk);
  endtask

  task automatic write_burst(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'($urandom);
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  initial begin
    int l0;
    int i;
    logic [7:0] hello [5];
    hello = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    repeat (3) @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dv", dv, 0);
    chk("rst_byte", tx_byte, 0);
    rst_n = 1'b1;
    @(negedge clk);

    wr_en = 1'b1;
    wr_data = 8'h68;
    @(negedge clk);
    wr_en = 1'b0;
    chk("single_dv_early", dv, 0);
    @(negedge clk);
    chk("single_dv_latency", dv, 1);
    chk("single_byte", tx_byte, 8'h68);
    drain();
    chk("single_empty_after", empty, 1);

    l0 = launches;
    for (int k = 0; k < 5; k++) begin
      wr_en = 1'b1;
      wr_data = hello[k];
      @(negedge clk);
    end
    wr_en = 1'b0;
    drain();
    chk("hello_launches", launches - l0, 5);

    force_hi = 1;
    tx_active = 1'b1;
    @(negedge clk);
    write_burst(17);
    chk("full_count", count, 16);
    chk("full_flag", full, 1);
    chk("ovf_pulse", ovf, 1);
    wr_en = 1'b1;
    wr_data = 8'hEE;
    force_hi = 0;
    tx_active = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
    chk("sim16_count", count, 15);
    chk("sim16_ovf", ovf, 1);
    drain();

    force_hi = 1;
    tx_active = 1'b1;
    @(negedge clk);
    write_burst(3);
    wr_en = 1'b1;
    wr_data = 8'h33;
    force_hi = 0;
    tx_active = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
    chk("sim3_count", count, 3);
    drain();

    no_resp = 1;
    l0 = launches;
    wr_en = 1'b1;
    wr_data = 8'hA5;
    @(negedge clk);
    wr_data = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0;
    drain();
    chk("timeout_launches", launches - l0, 2);
    no_resp = 0;

    rand_to = 1;
    for (int k = 0; k < 600; k++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_data = 8'($urandom);
      @(negedge clk);
    end
    wr_en = 1'b0;
    drain();
    rand_to = 0;

    len_lo = 30;
    len_hi = 30;
    write_burst(6);
    for (i = 0; i < 100; i++) begin
      if (tx_active && exp_q.size() == 5) break;
      @(negedge clk);
    end
    chk("midrst_setup_timeout", int'(i >= 100), 0);
    #5;
    rst_n = 1'b0;
    #1;
    chk("midrst_empty", empty, 1);
    chk("midrst_full", full, 0);
    chk("midrst_count", count, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_dv", dv, 0);
    chk("midrst_byte", tx_byte, 0);
    exp_q.delete();
    gap_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    l0 = launches;
    repeat (60) @(negedge clk);
    chk("midrst_no_launch", launches - l0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(32 * 60000);
    $display("FAIL watchdog: got no completion expected finish within 60000 cycles");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter DEPTH, default 16, meaning FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter START_TIMEOUT, default 4, meaning clocks to wait for i_Tx_Active after a launch.
REQ-003 i_Clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_Rst_N  input  1  reset, asynchronous, active-low.
REQ-005 i_Wr_En  input  1  producer write strobe, one byte per high cycle.
REQ-006 i_Wr_Data  input  8  byte to enqueue.
REQ-007 o_Full  output  1  registered; high when count == DEPTH.
REQ-008 o_Empty  output  1  registered; high when count == 0.
REQ-009 o_Count  output  log2(DEPTH)+1  registered occupancy.
REQ-010 o_Overflow  output  1  one-cycle pulse when a write is dropped.
REQ-011 o_Tx_DV  output  1  one-cycle launch strobe to the downstream serializer's i_Tx_DV.
REQ-012 o_Tx_Byte  output  8  byte to the serializer's i_Tx_Byte; held stable from launch until the next launch.
REQ-013 i_Tx_Active  input  1  serializer busy flag, from its o_Tx_Active.

Function
REQ-014 A write SHALL be accepted iff i_Wr_En=1 and o_Full=0 at the sampling edge; otherwise the byte SHALL be discarded and o_Overflow SHALL pulse high for the next cycle.
REQ-015 Storage SHALL be a circular buffer with read and write pointers of log2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-016 A write and a pop in the same cycle SHALL leave o_Count unchanged; o_Full/o_Empty SHALL reflect the resulting count.
REQ-017 A pop SHALL occur only in the cycle the FSM leaves IDLE with a launch.
REQ-018 FSM states: IDLE, WAIT_START, WAIT_DONE.
REQ-019 IDLE: if o_Empty=0 and i_Tx_Active=0 -> o_Tx_DV=1 and o_Tx_Byte=head entry on the next edge, pop, go to WAIT_START; otherwise stay.
REQ-020 WAIT_START: i_Tx_Active=1 -> WAIT_DONE; START_TIMEOUT clocks elapsed without i_Tx_Active -> IDLE (byte considered sent, no retry).
REQ-021 WAIT_DONE: i_Tx_Active=0 -> IDLE.
REQ-022 o_Tx_DV SHALL be high for exactly one clock per launch and never in WAIT_START or WAIT_DONE.
REQ-023 Latency: a byte written into an empty queue with the FSM in IDLE and the serializer idle SHALL produce o_Tx_DV=1 two edges after the accepting edge.
REQ-024 Back-to-back: with the queue non-empty, the next launch SHALL occur on the edge after i_Tx_Active is sampled low in WAIT_DONE plus one IDLE cycle.
REQ-025 Bytes SHALL leave in strict write order; no byte SHALL be launched twice.

Reset
REQ-026 While i_Rst_N=0: pointers and count = 0, o_Empty=1, o_Full=0, o_Overflow=0, o_Tx_DV=0, o_Tx_Byte=8'h00, FSM=IDLE.
REQ-027 Reset asserted mid-transfer SHALL discard all queued bytes; the serializer's in-flight frame is not the queue's concern.
REQ-028 Deassertion SHALL be honoured on the first rising edge after i_Rst_N rises; storage array contents need no reset.

Structure
REQ-029 FSM state encoding and default DEPTH/START_TIMEOUT SHALL live in the shared UART package alongside the serializer's constants.
REQ-030 The storage/pointer logic SHALL be one sub-module, sync_fifo (write, pop, full, empty, count); the launch FSM stays in uart_tx_queue.

Verification (i_Clock period 32 ns, queue driving the team's uart_tx at its configured baud)
REQ-031 Single byte: reset, write "h" (8'h68) once -> o_Tx_DV pulses 2 edges later with o_Tx_Byte=8'h68, serial line carries 0x68 frame, o_Empty=1 afterwards.
REQ-032 Ordering: write "h","e","l","l","o" on consecutive cycles -> exactly five o_Tx_DV pulses, bytes 68,65,6C,6C,6F in order, each launch only after i_Tx_Active falls.
REQ-033 Full/overflow: with i_Tx_Active forced high, write 17 bytes -> o_Full=1 after 16th, 17th dropped, o_Overflow one-cycle pulse, o_Count=16.
REQ-034 Simultaneous: at count=16, write coincident with launch pop -> write rejected (o_Full sampled high), count becomes 15; at count=3, write plus pop -> count stays 3.
REQ-035 Timeout: i_Tx_Active tied low, write 8'hA5 -> o_Tx_DV pulses, FSM returns to IDLE after 4 clocks, next byte launches.
REQ-036 Reset mid-operation: assert i_Rst_N=0 with 5 bytes queued during WAIT_DONE -> all outputs at REQ-026 values immediately (asynchronously), no further o_Tx_DV after release.
